// File: rtl/gf163_pkg.sv
// Shared constants and types for the GF(2^163) arithmetic blocks.
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;
    localparam int M  = 163;
    localparam int DW = 21;
    localparam int ND = 8;
    localparam int PW = ND * DW;      // padded operand width, 168
    localparam int AW = 2 * PW - 1;   // accumulator width, 335
    localparam int RW = 2 * M - 1;    // true product width, 325

    localparam int TAP0 = 0;
    localparam int TAP1 = 3;
    localparam int TAP2 = 6;
    localparam int TAP3 = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/gf163_reduce.sv
// Combinational reduction of a 325-bit product modulo f(x), in two folds.
module gf163_reduce
    import gf163_pkg::*;
(
    input  logic [RW-1:0] p,
    output logic [M-1:0]  r
);
    logic [M-2:0] hi;
    logic [M+6:0] t;
    logic [6:0]   hi2;

    always_comb begin
        hi  = p[RW-1:M];
        // x^163 == x^7 + x^6 + x^3 + 1, so each high bit lands at four offsets
        t   = {7'b0, p[M-1:0]};
        t   = t ^ ({8'b0, hi} << TAP0) ^ ({8'b0, hi} << TAP1)
                ^ ({8'b0, hi} << TAP2) ^ ({8'b0, hi} << TAP3);
        hi2 = t[M+6:M];
        r   = t[M-1:0] ^ (M'(hi2) << TAP0) ^ (M'(hi2) << TAP1)
                       ^ (M'(hi2) << TAP2) ^ (M'(hi2) << TAP3);
    end
endmodule

// File: rtl/karatsuba21.sv
// Combinational 21x21 carry-less multiplier, one Karatsuba level (11/10 split).
module karatsuba21 (
    input  logic [20:0] a,
    input  logic [20:0] b,
    output logic [40:0] p
);
    function automatic logic [40:0] clmul(input logic [20:0] x, input logic [20:0] y);
        logic [40:0] r;
        r = '0;
        for (int k = 0; k < 21; k++)
            if (y[k]) r = r ^ ({20'b0, x} << k);
        return r;
    endfunction

    logic [40:0] z0, z1, z2;

    always_comb begin
        z0 = clmul({10'b0, a[10:0]}, {10'b0, b[10:0]});
        z2 = clmul({11'b0, a[20:11]}, {11'b0, b[20:11]});
        z1 = clmul({10'b0, a[10:0] ^ {1'b0, a[20:11]}},
                   {10'b0, b[10:0] ^ {1'b0, b[20:11]}});
        // Middle term is (a0+a1)(b0+b1) - z0 - z2; subtraction is XOR in GF(2)
        p  = (z2 << 22) ^ ((z1 ^ z0 ^ z2) << 11) ^ z0;
    end
endmodule

// File: rtl/gf163_mul_seq.sv
// Sequential GF(2^163) multiplier: 64 digit products through one karatsuba21
// core into a 335-bit accumulator, then one reduction cycle.
module gf163_mul_seq
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c,
    output logic         busy
);
    state_t          state;
    logic [PW-1:0]   a_pad, b_pad;
    logic [AW-1:0]   acc;
    logic [2:0]      i, j;
    logic [DW-1:0]   a_dig, b_dig;
    logic [2*DW-2:0] prod;
    logic [M-1:0]    c_red;
    logic            unused_acc_hi;

    assign a_dig = a_pad[DW*i +: DW];
    assign b_dig = b_pad[DW*j +: DW];

    karatsuba21 u_core (
        .a (a_dig),
        .b (b_dig),
        .p (prod)
    );

    gf163_reduce u_red (
        .p (acc[RW-1:0]),
        .r (c_red)
    );

    // Zero padding keeps acc[334:325] clear, so they never feed the reduction
    assign unused_acc_hi = ^acc[AW-1:RW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            c         <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            a_pad     <= '0;
            b_pad     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_pad    <= {{(PW-M){1'b0}}, a};
                        b_pad    <= {{(PW-M){1'b0}}, b};
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc[DW*(32'(i) + 32'(j)) +: 2*DW-1] <=
                        acc[DW*(32'(i) + 32'(j)) +: 2*DW-1] ^ prod;
                    j <= j + 3'd1;
                    if (j == 3'd7) i <= i + 3'd1;
                    if (i == 3'd7 && j == 3'd7) state <= RED;
                end
                RED: begin
                    c         <= c_red;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf163_mul_seq.sv
// Directed and random checks of gf163_mul_seq against hand values and a
// bit-serial shift-and-reduce model.
module tb_gf163_mul_seq;
    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic         in_ready, out_valid, busy;
    logic [162:0] a, b, c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gf163_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [162:0] got, input logic [162:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [162:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
        logic [163:0] r;
        r = '0;
        for (int k = 162; k >= 0; k--) begin
            r = r << 1;
            if (r[163]) r = r ^ {1'b1, 155'b0, 8'hC9};
            if (y[k]) r = r ^ {1'b0, x};
        end
        return r[162:0];
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[162:0];
    endfunction

    // Called right after a negedge; returns right after the negedge of cycle t0+1.
    task automatic start(input logic [162:0] xa, input logic [162:0] xb);
        int w;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_start", 163'(in_ready), 163'd1);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic ir_seen, output logic busy_lo);
        lat = 1;
        ir_seen = 1'b0;
        busy_lo = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_seen = 1'b1;
            if (!busy) busy_lo = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [162:0] xa, input logic [162:0] xb,
                       output logic [162:0] res, output int lat);
        logic ir, bl;
        start(xa, xb);
        wait_done(lat, ir, bl);
        res = c;
        accept();
    endtask

    initial begin
        logic [162:0] x162, x1, res, ra, rb, held, all1;
        int lat;
        logic ir, bl, stable_bad, ir_bad;

        x162 = 163'h1 << 162;
        x1   = 163'h2;
        all1 = '1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

        #12;
        chk("rst_in_ready",  163'(in_ready),  163'd1);
        chk("rst_out_valid", 163'(out_valid), 163'd0);
        chk("rst_busy",      163'(busy),      163'd0);
        chk("rst_c",         c,               163'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1 * 1, latency and handshake
        start(163'd1, 163'd1);
        wait_done(lat, ir, bl);
        chk("lat_1x1",          163'(lat), 163'd66);
        chk("c_1x1",            c,         163'd1);
        chk("in_ready_low_run", 163'(ir),  163'd0);
        chk("busy_high_run",    163'(bl),  163'd0);
        chk("busy_low_done",    163'(busy), 163'd0);
        chk("in_ready_done",    163'(in_ready), 163'd0);
        accept();
        chk("out_valid_drop",   163'(out_valid), 163'd0);
        chk("in_ready_back",    163'(in_ready),  163'd1);
        chk("c_holds",          c,               163'd1);

        run(x162, x1, res, lat);
        chk("c_x162_x", res, 163'hC9);

        run(x162, x162, res, lat);
        chk("c_x324", res, (163'h1 << 161) | 163'h1422);

        run(163'd0, all1, res, lat);
        chk("c_zero", res, 163'd0);

        // Back-pressure with in_valid pulses while DONE
        start(x162, x1);
        wait_done(lat, ir, bl);
        held = c;
        stable_bad = 1'b0;
        ir_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            a = 163'd3;
            b = 163'd3;
            @(negedge clk);
            if (c !== held || out_valid !== 1'b1) stable_bad = 1'b1;
            if (in_ready) ir_bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_c",        held,             163'hC9);
        chk("bp_stable",   163'(stable_bad), 163'd0);
        chk("bp_in_ready", 163'(ir_bad),     163'd0);
        accept();
        chk("bp_release_ov", 163'(out_valid), 163'd0);
        chk("bp_release_ir", 163'(in_ready),  163'd1);
        chk("bp_release_c",  c,               163'hC9);

        // Reset in the middle of MUL, at cycle t0+30
        start(all1, x162);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ov",   163'(out_valid), 163'd0);
        chk("mid_rst_ir",   163'(in_ready),  163'd1);
        chk("mid_rst_busy", 163'(busy),      163'd0);
        chk("mid_rst_c",    c,               163'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(163'd3, 163'd5, res, lat);
        chk("after_rst_c",   res,        163'hF);
        chk("after_rst_lat", 163'(lat),  163'd66);

        for (int k = 0; k < 1000; k++) begin
            ra = rnd163();
            rb = rnd163();
            if (k == 0) ra = '0;
            if (k == 1) begin ra = all1; rb = all1; end
            if (k == 2) rb = all1;
            run(ra, rb, res, lat);
            chk($sformatf("rand%0d", k), res, ref_mul(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
